// File: rtl/llc_ctrl_fsm.sv
// Sequencing controller for a 4-way set-associative LLC tag store with tree pseudo-LRU.
// Optional statistics counters are built when LLC_CTRL_STATS_EN is defined.
module llc_ctrl_fsm #(
  parameter int SETS     = 4,
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_cmd,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [1:0]        resp_way,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_ack,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt,
  output logic [31:0]       wb_cnt
);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFFSET_W;
  localparam int LINE_W = ADDR_W - OFFSET_W;

  localparam logic [3:0] CMD_READ  = 4'd0;
  localparam logic [3:0] CMD_WRITE = 4'd1;
  localparam logic [3:0] CMD_INVAL = 4'd2;
  localparam logic [3:0] CMD_CLEAR = 4'd8;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WB, WB_WAIT, FILL, FILL_WAIT, CLR, RESP
  } state_t;

  state_t               state_reg, state_next;
  logic [3:0]           cmd_reg, cmd_next;
  logic [LINE_W-1:0]    line_reg, line_next;
  logic [1:0]           victim_reg, victim_next;
  logic [TAG_W-1:0]     victim_tag_reg, victim_tag_next;
  logic                 resp_hit_reg, resp_hit_next;
  logic [1:0]           resp_way_reg, resp_way_next;
  logic [IDX_W-1:0]     clr_idx_reg, clr_idx_next;

  logic [TAG_W-1:0]     tag_reg   [SETS][4];
  logic [3:0]           valid_reg [SETS];
  logic [3:0]           dirty_reg [SETS];
  logic [2:0]           plru_reg  [SETS];

  logic [IDX_W-1:0]     idx;
  logic [TAG_W-1:0]     req_tag;
  logic [3:0]           hit_vec;
  logic                 hit_any;
  logic [1:0]           hit_way;
  logic [1:0]           victim_sel;
  logic                 do_touch, do_set_dirty, do_inval, do_install, do_clr;
  logic                 unused_offset;

  // Byte-select bits never matter to the tag store.
  assign unused_offset = ^req_addr[OFFSET_W-1:0];

  assign idx     = line_reg[IDX_W-1:0];
  assign req_tag = line_reg[LINE_W-1 -: TAG_W];

  function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [1:0] w);
    logic [2:0] n;
    n = p;
    case (w)
      2'd0:    begin n[1] = 1'b0; n[0] = 1'b0; end
      2'd1:    begin n[1] = 1'b1; n[0] = 1'b0; end
      2'd2:    begin n[0] = 1'b1; n[2] = 1'b0; end
      default: begin n[0] = 1'b1; n[2] = 1'b1; end
    endcase
    return n;
  endfunction

  function automatic logic [1:0] plru_victim(input logic [2:0] p);
    if (!p[0]) return p[2] ? 2'd2 : 2'd3;
    else       return p[1] ? 2'd0 : 2'd1;
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_cmp
    assign hit_vec[gi] = valid_reg[idx][gi] && (tag_reg[idx][gi] == req_tag);
  end
  assign hit_any = |hit_vec;

  always_comb begin
    hit_way = 2'd0;
    for (int w = 3; w >= 0; w--) if (hit_vec[w]) hit_way = 2'(w);
  end

  // Empty ways are filled lowest-first before the PLRU tree is consulted.
  always_comb begin
    victim_sel = plru_victim(plru_reg[idx]);
    for (int w = 3; w >= 0; w--) if (!valid_reg[idx][w]) victim_sel = 2'(w);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cmd_reg        <= '0;
      line_reg       <= '0;
      victim_reg     <= '0;
      victim_tag_reg <= '0;
      resp_hit_reg   <= 1'b0;
      resp_way_reg   <= '0;
      clr_idx_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      cmd_reg        <= cmd_next;
      line_reg       <= line_next;
      victim_reg     <= victim_next;
      victim_tag_reg <= victim_tag_next;
      resp_hit_reg   <= resp_hit_next;
      resp_way_reg   <= resp_way_next;
      clr_idx_reg    <= clr_idx_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cmd_next        = cmd_reg;
    line_next       = line_reg;
    victim_next     = victim_reg;
    victim_tag_next = victim_tag_reg;
    resp_hit_next   = resp_hit_reg;
    resp_way_next   = resp_way_reg;
    clr_idx_next    = clr_idx_reg;
    do_touch        = 1'b0;
    do_set_dirty    = 1'b0;
    do_inval        = 1'b0;
    do_install      = 1'b0;
    do_clr          = 1'b0;
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    resp_hit        = 1'b0;
    resp_way        = 2'd0;
    mem_req_valid   = 1'b0;
    mem_req_write   = 1'b0;
    mem_req_addr    = '0;

    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cmd_next   = req_cmd;
          line_next  = req_addr[ADDR_W-1:OFFSET_W];
          state_next = LOOKUP;
        end
      end
      LOOKUP: begin
        resp_hit_next = 1'b0;
        resp_way_next = 2'd0;
        state_next    = RESP;
        case (cmd_reg)
          CMD_READ, CMD_WRITE: begin
            if (hit_any) begin
              do_touch      = 1'b1;
              do_set_dirty  = (cmd_reg == CMD_WRITE);
              resp_hit_next = 1'b1;
              resp_way_next = hit_way;
            end else begin
              victim_next     = victim_sel;
              victim_tag_next = tag_reg[idx][victim_sel];
              state_next      = (valid_reg[idx][victim_sel] && dirty_reg[idx][victim_sel]) ? WB : FILL;
            end
          end
          CMD_INVAL: begin
            if (hit_any) begin
              do_inval      = 1'b1;
              resp_hit_next = 1'b1;
              resp_way_next = hit_way;
            end
          end
          CMD_CLEAR: begin
            clr_idx_next = '0;
            state_next   = CLR;
          end
          default: ;
        endcase
      end
      WB: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {victim_tag_reg, idx, {OFFSET_W{1'b0}}};
        if (mem_req_ready) state_next = WB_WAIT;
      end
      WB_WAIT: if (mem_ack) state_next = FILL;
      FILL: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_tag, idx, {OFFSET_W{1'b0}}};
        if (mem_req_ready) state_next = FILL_WAIT;
      end
      FILL_WAIT: begin
        if (mem_ack) begin
          do_install    = 1'b1;
          resp_hit_next = 1'b0;
          resp_way_next = victim_reg;
          state_next    = RESP;
        end
      end
      CLR: begin
        do_clr = 1'b1;
        if (clr_idx_reg == IDX_W'(SETS - 1)) state_next = RESP;
        else                                 clr_idx_next = clr_idx_reg + 1'b1;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_hit   = resp_hit_reg;
        resp_way   = resp_way_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (rst) begin
      req_ready     = 1'b0;
      resp_valid    = 1'b0;
      resp_hit      = 1'b0;
      resp_way      = 2'd0;
      mem_req_valid = 1'b0;
    end
  end

  // Tags carry no reset; a line is only meaningful while its valid bit is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_reg[s] <= '0;
        dirty_reg[s] <= '0;
        plru_reg[s]  <= '0;
      end
    end else begin
      if (do_touch) begin
        plru_reg[idx] <= plru_touch(plru_reg[idx], hit_way);
        if (do_set_dirty) dirty_reg[idx][hit_way] <= 1'b1;
      end
      if (do_inval) begin
        valid_reg[idx][hit_way] <= 1'b0;
        dirty_reg[idx][hit_way] <= 1'b0;
      end
      if (do_install) begin
        tag_reg[idx][victim_reg]   <= req_tag;
        valid_reg[idx][victim_reg] <= 1'b1;
        dirty_reg[idx][victim_reg] <= (cmd_reg == CMD_WRITE);
        plru_reg[idx]              <= plru_touch(plru_reg[idx], victim_reg);
      end
      if (do_clr) begin
        valid_reg[clr_idx_reg] <= '0;
        dirty_reg[clr_idx_reg] <= '0;
        plru_reg[clr_idx_reg]  <= '0;
      end
    end
  end

`ifdef LLC_CTRL_STATS_EN
  logic [31:0] hit_cnt_reg, miss_cnt_reg, wb_cnt_reg;
  logic        wb_hs;
  logic        rw_resp;

  assign wb_hs   = (state_reg == WB) && mem_req_ready;
  assign rw_resp = (state_reg == RESP) && ((cmd_reg == CMD_READ) || (cmd_reg == CMD_WRITE));

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
      wb_cnt_reg   <= '0;
    end else begin
      if (rw_resp && resp_hit_reg)  hit_cnt_reg  <= hit_cnt_reg + 1'b1;
      if (rw_resp && !resp_hit_reg) miss_cnt_reg <= miss_cnt_reg + 1'b1;
      if (wb_hs)                    wb_cnt_reg   <= wb_cnt_reg + 1'b1;
    end
  end

  assign hit_cnt  = hit_cnt_reg;
  assign miss_cnt = miss_cnt_reg;
  assign wb_cnt   = wb_cnt_reg;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
  assign wb_cnt   = '0;
`endif

endmodule

// File: tb/tb_llc_ctrl_fsm.sv
// Scoreboard bench for llc_ctrl_fsm: directed commands push expected responses and memory
// requests into queues; a monitor pops and compares whenever the DUT presents them.
module tb_llc_ctrl_fsm;
  localparam int SETS     = 4;
  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [3:0]        req_cmd = 4'd0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              resp_valid, resp_hit;
  logic [1:0]        resp_way;
  logic              mem_req_valid, mem_req_write;
  logic              mem_req_ready = 1'b0;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_ack;
  logic              ack_drv = 1'b0;
  logic              inj_ack = 1'b0;
  logic [31:0]       hit_cnt, miss_cnt, wb_cnt;

  assign mem_ack = ack_drv | inj_ack;

  always #5 clk = ~clk;

  llc_ctrl_fsm #(.SETS(SETS), .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
  );

  typedef struct packed { logic hit; logic [1:0] way; } resp_t;
  typedef struct packed { logic wr; logic [31:0] addr; } memreq_t;

  resp_t   exp_resp[$];
  memreq_t exp_mem[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int resp_seen = 0;
  int mem_seen = 0;
  int last_resp_cyc = 0;
  int stall_cycles = 0;
  bit drop_ack = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_cmp++;
    n_err++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  // Monitor: compares responses, memory handshakes and request stability under back-pressure.
  initial begin
    resp_t   er;
    memreq_t em;
    logic        hold_pending = 1'b0;
    logic [31:0] hold_addr = '0;
    logic        hold_wr = 1'b0;
    logic        prev_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_pending = 1'b0;
        prev_resp    = 1'b0;
      end else begin
        if (prev_resp) check("ready_after_resp", req_ready, 1);
        prev_resp = resp_valid;
        if (resp_valid) begin
          $display("resp cycle=%0d hit=%0b way=%0d", cyc, resp_hit, resp_way);
          if (exp_resp.size() == 0) fail_now("resp_unexpected", "response with none pending");
          else begin
            er = exp_resp.pop_front();
            check("resp_hit", resp_hit, er.hit);
            check("resp_way", resp_way, er.way);
          end
          resp_seen++;
          last_resp_cyc = cyc;
        end
        if (hold_pending) begin
          check("mem_hold_valid", mem_req_valid, 1);
          check("mem_hold_addr", mem_req_addr, hold_addr);
          check("mem_hold_write", mem_req_write, hold_wr);
        end
        hold_pending = mem_req_valid && !mem_req_ready;
        hold_addr    = mem_req_addr;
        hold_wr      = mem_req_write;
        if (mem_req_valid && mem_req_ready) begin
          $display("mem_req cycle=%0d write=%0b addr=0x%08h", cyc, mem_req_write, mem_req_addr);
          if (exp_mem.size() == 0) fail_now("mem_unexpected", "memory request with none pending");
          else begin
            em = exp_mem.pop_front();
            check("mem_write", mem_req_write, em.wr);
            check("mem_addr", mem_req_addr, em.addr);
          end
          mem_seen++;
        end
      end
    end
  end

  // Memory responder: optional stall before ready, ack two cycles after the handshake.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (mem_req_valid) begin
        repeat (stall_cycles) begin @(posedge clk); #1; end
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        if (!drop_ack) begin
          ack_drv = 1'b1;
          @(posedge clk); #1;
          ack_drv = 1'b0;
        end
      end
    end
  end

  task automatic push_mem(input logic wr, input logic [31:0] addr);
    memreq_t m;
    m.wr = wr;
    m.addr = addr;
    exp_mem.push_back(m);
  endtask

  task automatic send(input logic [3:0] cmd, input logic [31:0] addr, output int acc_cyc);
    int guard = 0;
    @(posedge clk); #1;
    while (!req_ready && guard < 500) begin @(posedge clk); #1; guard++; end
    if (!req_ready) fail_now("ready_timeout", "req_ready never rose");
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_addr  = addr;
    acc_cyc   = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_op(input logic [3:0] cmd, input logic [31:0] addr,
                       input logic hit, input logic [1:0] way, output int lat);
    resp_t r;
    int acc, prev, guard;
    r.hit = hit;
    r.way = way;
    exp_resp.push_back(r);
    prev = resp_seen;
    send(cmd, addr, acc);
    guard = 0;
    while (resp_seen == prev && guard < 2000) begin @(negedge clk); guard++; end
    if (resp_seen == prev) fail_now("resp_timeout", "no response within budget");
    lat = last_resp_cyc - acc;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_mem_req_valid", mem_req_valid, 0);
    @(negedge clk);
    check("rst_resp_hit", resp_hit, 0);
    check("rst_resp_way", resp_way, 0);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_wb_cnt", wb_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", req_ready, 1);
  endtask

  initial begin
    $display("*** WATCHDOG armed ***");
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, acc, guard, prev;
    logic [31:0] exp_wb, exp_miss, exp_hit;

    // Basic miss/fill, hit latency, no-op and invalidate
    apply_reset();
    push_mem(1'b0, 32'h0000_1040);
    do_op(4'd0, 32'h0000_1040, 1'b0, 2'd0, lat);
    do_op(4'd0, 32'h0000_1040, 1'b1, 2'd0, lat);
    check("hit_latency", lat, 2);
    do_op(4'd5, 32'h0000_1040, 1'b0, 2'd0, lat);
    do_op(4'd2, 32'h0000_1040, 1'b1, 2'd0, lat);
    push_mem(1'b0, 32'h0000_1040);
    do_op(4'd0, 32'h0000_1040, 1'b0, 2'd0, lat);
    do_op(4'd2, 32'h0000_3040, 1'b0, 2'd0, lat);
    do_op(4'd0, 32'h0000_1040, 1'b1, 2'd0, lat);

    // Fill set 1, PLRU replacement
    apply_reset();
    push_mem(1'b0, 32'h0000_0140); do_op(4'd0, 32'h0000_0140, 1'b0, 2'd0, lat);
    push_mem(1'b0, 32'h0000_0240); do_op(4'd0, 32'h0000_0240, 1'b0, 2'd1, lat);
    push_mem(1'b0, 32'h0000_0340); do_op(4'd0, 32'h0000_0340, 1'b0, 2'd2, lat);
    push_mem(1'b0, 32'h0000_0440); do_op(4'd0, 32'h0000_0440, 1'b0, 2'd3, lat);
    push_mem(1'b0, 32'h0000_0540); do_op(4'd0, 32'h0000_0540, 1'b0, 2'd0, lat);
    do_op(4'd0, 32'h0000_0240, 1'b1, 2'd1, lat);
    push_mem(1'b0, 32'h0000_0640); do_op(4'd0, 32'h0000_0640, 1'b0, 2'd2, lat);

    // Dirty writeback with memory back-pressure
    apply_reset();
    stall_cycles = 5;
    push_mem(1'b0, 32'h0000_0080); do_op(4'd1, 32'h0000_0080, 1'b0, 2'd0, lat);
    push_mem(1'b0, 32'h0000_0180); do_op(4'd0, 32'h0000_0180, 1'b0, 2'd1, lat);
    push_mem(1'b0, 32'h0000_0280); do_op(4'd0, 32'h0000_0280, 1'b0, 2'd2, lat);
    push_mem(1'b0, 32'h0000_0380); do_op(4'd0, 32'h0000_0380, 1'b0, 2'd3, lat);
    push_mem(1'b1, 32'h0000_0080);
    push_mem(1'b0, 32'h0000_0480); do_op(4'd0, 32'h0000_0480, 1'b0, 2'd0, lat);
    stall_cycles = 0;
    @(posedge clk); #1;
`ifdef LLC_CTRL_STATS_EN
    exp_wb = 32'd1; exp_miss = 32'd5; exp_hit = 32'd0;
`else
    exp_wb = 32'd0; exp_miss = 32'd0; exp_hit = 32'd0;
`endif
    check("wb_cnt", wb_cnt, exp_wb);
    check("miss_cnt", miss_cnt, exp_miss);
    check("hit_cnt", hit_cnt, exp_hit);

    // Stray ack in IDLE must be ignored
    @(posedge clk); #1; inj_ack = 1'b1;
    @(posedge clk); #1; inj_ack = 1'b0;
    @(negedge clk);
    check("ack_idle_ready", req_ready, 1);
    check("ack_idle_memvalid", mem_req_valid, 0);
    do_op(4'd0, 32'h0000_0480, 1'b1, 2'd0, lat);
    check("hit_latency2", lat, 2);

    // Clear walks every set, then prior lines miss without writeback
    do_op(4'd8, 32'h0000_0000, 1'b0, 2'd0, lat);
    check("clear_latency", lat, SETS + 2);
    push_mem(1'b0, 32'h0000_0480); do_op(4'd0, 32'h0000_0480, 1'b0, 2'd0, lat);
    push_mem(1'b0, 32'h0000_0180); do_op(4'd0, 32'h0000_0180, 1'b0, 2'd1, lat);

    // Reset during FILL_WAIT abandons the fill
    drop_ack = 1'b1;
    push_mem(1'b0, 32'h0000_2040);
    prev = mem_seen;
    send(4'd0, 32'h0000_2040, acc);
    guard = 0;
    while (mem_seen == prev && guard < 500) begin @(negedge clk); guard++; end
    if (mem_seen == prev) fail_now("fill_hs_timeout", "fill handshake never seen");
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_memvalid", mem_req_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_memvalid_after", mem_req_valid, 0);
    check("rst_mid_ready", req_ready, 1);
    repeat (6) @(posedge clk);
    drop_ack = 1'b0;
    repeat (2) @(posedge clk);
    check("rst_mid_no_resp", exp_resp.size(), 0);
    push_mem(1'b0, 32'h0000_2040); do_op(4'd0, 32'h0000_2040, 1'b0, 2'd0, lat);

    repeat (3) @(posedge clk);
    check("resp_queue_drained", exp_resp.size(), 0);
    check("mem_queue_drained", exp_mem.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
